stream_wrr_arbiter: RTL and testbench
=====================================

Name: stream_wrr_arbiter

Overview:
Packet-aware weighted round-robin arbiter that shares one AXI-Stream output between NPORT input streams, typically the FIFO outputs feeding the cell-controller stream path. A grant is held for whole packets, up to a per-port weight of packets per grant, then rotates. Provides per-port request suppression, a packet counter and a sticky mid-packet stall flag for diagnostics.

Parameters:
DW, 32, tdata width per stream
NPORT, 4, number of input streams (2..8)
SW, $clog2(NPORT), width of select/pointer
STALL_LIMIT, 1024, cycles of mid-packet source starvation before stall_err sets (>=2)

Ports:
aclk  in  1  single clock for all logic
areset  in  1  synchronous reset, active-high
s_tvalid  in  NPORT  per-port valid
s_tready  out  NPORT  per-port ready
s_tdata  in  NPORT*DW  port i at [i*DW +: DW]
s_tlast  in  NPORT  per-port end of packet
arb_req_suppress  in  NPORT  1 = port ineligible for new grants
weight  in  NPORT*4  packets per grant, port i at [i*4 +: 4]; 0 treated as 1
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tdata  out  DW  output data
m_tlast  out  1  output end of packet
m_tsel  out  SW  currently granted port
busy  out  1  1 while in GRANT
pkts_out  out  32  packets forwarded, wraps at 2^32
stall_err  out  1  sticky mid-packet stall flag

Behaviour:
- Reset (synchronous, areset=1 at posedge): state=IDLE, ptr=0, sel=0, credits=0, pkt_open=0, stall_cnt=0, pkts_out=0, stall_err=0. Outputs: m_tvalid=0, s_tready=0, busy=0, m_tsel=0. Reset mid-packet abandons the packet; the remaining source beats are presented as a new packet after re-grant.
- eligible[i] = s_tvalid[i] & ~arb_req_suppress[i].
- IDLE: no transfers, all s_tready=0, m_tvalid=0. If any eligible: sel <= first eligible index searching ptr, ptr+1, ... mod NPORT; credits <= max(weight[sel],1); pkt_open <= 0; state <= GRANT. Otherwise stay in IDLE.
- GRANT: m_tvalid=s_tvalid[sel], m_tdata=s_tdata[sel], m_tlast=s_tlast[sel], s_tready[sel]=m_tready, other s_tready=0. All combinational from sel. busy=1, m_tsel=sel.
- beat = m_tvalid & m_tready. Beat with tlast=0: pkt_open<=1. Beat with tlast=1: pkt_open<=0, pkts_out+1, credits-1. If credits reaches 0: ptr <= (sel+1) mod NPORT, state <= IDLE.
- Release at a packet boundary: in GRANT with pkt_open=0, no beat this cycle, and (s_tvalid[sel]=0 or arb_req_suppress[sel]=1): ptr <= (sel+1) mod NPORT, state <= IDLE.
- Suppress is honoured only at packet boundaries. Asserting it mid-packet never truncates the packet.
- Latency: a port eligible in IDLE at cycle t has m_tvalid=1 at t+1. Exactly one IDLE bubble occurs between consecutive grants, including a re-grant to the same port.
- Single-port fairness: with only port k requesting, port k is re-granted after each IDLE bubble. With all ports requesting and all weights at 1, the grant order is 0,1,2,3,0...
- Stall detection: in GRANT with pkt_open=1 and s_tvalid[sel]=0, stall_cnt increments, saturating at STALL_LIMIT. Any other cycle clears stall_cnt to 0. When stall_cnt reaches STALL_LIMIT, stall_err <= 1 and stays set until reset. The grant is not released while stalled.
- m_tready low: the beat is held, and credits and counters are unchanged.
- Weight sampling: weight is sampled only at grant time. Changes during GRANT take effect at the next grant.

Test Plan:
- Reset then idle: areset=1 for 2 cycles, all s_tvalid=0 -> m_tvalid=0, s_tready=0, busy=0, pkts_out=0 for 10 cycles.
- Equal weights: ports 0-3 each stream 4-beat packets continuously, weight=1, m_tready=1 -> m_tsel sequence 0,1,2,3,0; each grant 4 beats plus 1 bubble; pkts_out=8 after 8 packets.
- Weighted: weight0=3, weight1=1, both continuously valid -> packet order 0,0,0,1,0,0,0,1; no bubble inside the port-0 run; one bubble per grant change.
- Suppress and backpressure: assert arb_req_suppress[1] on beat 2 of a 5-beat port-1 packet, m_tready toggling 1/0 -> all 5 beats delivered in order, tlast on beat 5; port 1 not regranted while suppressed; ports 0,2 served.
- Stall: STALL_LIMIT=16, port 2 sends 2 beats of a packet then drops tvalid for 20 cycles -> stall_err=1 at 16th idle cycle, grant held (m_tsel=2), remaining beats forwarded on resume, stall_err stays 1.
- Reset mid-packet: areset pulsed on beat 3 of a port-0 packet -> next cycle busy=0, ptr=0; port 0 regranted one cycle after reset deasserts if still eligible; pkts_out=0.

Source files
------------

// File: rtl/stream_wrr_arbiter_if.sv
// Stream bundle for the weighted round-robin arbiter: NPORT input streams and one merged output.
// The slave modport is the arbiter's view; master is the surrounding logic that sources and sinks data.
interface stream_wrr_arbiter_if #(
    parameter int DW    = 32,
    parameter int NPORT = 4,
    parameter int SW    = $clog2(NPORT)
);
    logic [NPORT-1:0]    s_tvalid;
    logic [NPORT-1:0]    s_tready;
    logic [NPORT*DW-1:0] s_tdata;
    logic [NPORT-1:0]    s_tlast;
    logic                m_tvalid;
    logic                m_tready;
    logic [DW-1:0]       m_tdata;
    logic                m_tlast;
    logic [SW-1:0]       m_tsel;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tsel
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tsel
    );
endinterface

// File: rtl/stream_wrr_arbiter.sv
// Packet-aware weighted round-robin arbiter: grants are held for whole packets, up to a
// per-port packet budget, with request suppression, a packet counter and a sticky stall flag.
module stream_wrr_arbiter #(
    parameter int DW          = 32,
    parameter int NPORT       = 4,
    parameter int SW          = $clog2(NPORT),
    parameter int STALL_LIMIT = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    stream_wrr_arbiter_if.slave  axis,
    input  logic [NPORT-1:0]     arb_req_suppress,
    input  logic [NPORT*4-1:0]   weight,
    output logic                 busy,
    output logic [31:0]          pkts_out,
    output logic                 stall_err
);
    localparam int            CW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW:0]   NP = (SW+1)'(NPORT);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   ptr_reg, ptr_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [3:0]      credits_reg, credits_next;
    logic            pkt_open_reg, pkt_open_next;
    logic [CW-1:0]   stall_cnt_reg, stall_cnt_next;
    logic [31:0]     pkts_out_reg, pkts_out_next;
    logic            stall_err_reg, stall_err_next;

    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] rot_elig;
    logic [SW-1:0]    rot_idx [NPORT];
    logic [3:0]       weight_arr [NPORT];
    logic [DW-1:0]    data_arr [NPORT];
    logic [SW-1:0]    off;
    logic [SW-1:0]    pick;
    logic [SW-1:0]    sel_inc;
    logic             any_elig;
    logic             in_grant;
    logic             beat;

    assign eligible = axis.s_tvalid & ~arb_req_suppress;
    assign any_elig = |eligible;
    assign in_grant = (state_reg == GRANT);

    // rot_elig[k] is the eligibility of port (ptr + k) mod NPORT, so the lowest set bit wins.
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
        logic [SW:0] sum;
        assign sum            = {1'b0, ptr_reg} + (SW+1)'(gi);
        assign rot_idx[gi]    = (sum >= NP) ? SW'(sum - NP) : SW'(sum);
        assign rot_elig[gi]   = eligible[rot_idx[gi]];
        assign weight_arr[gi] = weight[gi*4 +: 4];
        assign data_arr[gi]   = axis.s_tdata[gi*DW +: DW];
        assign axis.s_tready[gi] = in_grant && (sel_reg == SW'(gi)) && axis.m_tready;
    end

    always_comb begin
        off = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (rot_elig[k]) off = SW'(k);
        end
    end

    assign pick    = rot_idx[off];
    assign sel_inc = (sel_reg == SW'(NPORT - 1)) ? '0 : sel_reg + 1'b1;

    assign axis.m_tvalid = in_grant & axis.s_tvalid[sel_reg];
    assign axis.m_tdata  = data_arr[sel_reg];
    assign axis.m_tlast  = in_grant & axis.s_tlast[sel_reg];
    assign axis.m_tsel   = sel_reg;
    assign beat          = axis.m_tvalid & axis.m_tready;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        sel_next       = sel_reg;
        credits_next   = credits_reg;
        pkt_open_next  = pkt_open_reg;
        pkts_out_next  = pkts_out_reg;
        stall_cnt_next = '0;
        stall_err_next = stall_err_reg;
        case (state_reg)
            IDLE: begin
                if (any_elig) begin
                    sel_next      = pick;
                    credits_next  = (weight_arr[pick] == 4'd0) ? 4'd1 : weight_arr[pick];
                    pkt_open_next = 1'b0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    if (axis.s_tlast[sel_reg]) begin
                        pkt_open_next = 1'b0;
                        pkts_out_next = pkts_out_reg + 32'd1;
                        credits_next  = credits_reg - 4'd1;
                        if (credits_next == 4'd0) begin
                            ptr_next   = sel_inc;
                            state_next = IDLE;
                        end
                    end else begin
                        pkt_open_next = 1'b1;
                    end
                end else if (!pkt_open_reg &&
                             (!axis.s_tvalid[sel_reg] || arb_req_suppress[sel_reg])) begin
                    ptr_next   = sel_inc;
                    state_next = IDLE;
                end
                // Source starved mid-packet: keep the grant, count the starvation.
                if (pkt_open_reg && !axis.s_tvalid[sel_reg]) begin
                    stall_cnt_next = (stall_cnt_reg == CW'(STALL_LIMIT)) ? stall_cnt_reg
                                                                        : stall_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stall_cnt_next == CW'(STALL_LIMIT)) stall_err_next = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            sel_reg       <= '0;
            credits_reg   <= '0;
            pkt_open_reg  <= 1'b0;
            stall_cnt_reg <= '0;
            pkts_out_reg  <= '0;
            stall_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            sel_reg       <= sel_next;
            credits_reg   <= credits_next;
            pkt_open_reg  <= pkt_open_next;
            stall_cnt_reg <= stall_cnt_next;
            pkts_out_reg  <= pkts_out_next;
            stall_err_reg <= stall_err_next;
        end
    end

    assign busy      = in_grant;
    assign pkts_out  = pkts_out_reg;
    assign stall_err = stall_err_reg;
endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Scoreboard bench for stream_wrr_arbiter: per-port packet sources, a hand-ordered expected
// beat queue, and a negedge monitor that pops and compares every output beat.
module tb_stream_wrr_arbiter;
    localparam int DW    = 32;
    localparam int NPORT = 4;
    localparam int SL    = 16;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  arb_req_suppress = '0;
    logic [15:0] weight = 16'h1111;
    logic        busy;
    logic [31:0] pkts_out;
    logic        stall_err;

    stream_wrr_arbiter_if #(.DW(DW), .NPORT(NPORT)) bus ();

    stream_wrr_arbiter #(.DW(DW), .NPORT(NPORT), .STALL_LIMIT(SL)) dut (
        .aclk             (clk),
        .areset           (areset),
        .axis             (bus),
        .arb_req_suppress (arb_req_suppress),
        .weight           (weight),
        .busy             (busy),
        .pkts_out         (pkts_out),
        .stall_err        (stall_err)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [32:0]      src_mem [NPORT][64];
    int               src_wr [NPORT];
    int               src_rd [NPORT];
    int               pops [NPORT];
    int               hold_after [NPORT];
    int               hold_rem [NPORT];
    int               hold_len = 20;
    bit               tog_mode = 1'b0;
    logic [NPORT-1:0] fire_s = '0;
    logic [34:0]      exp_q [$];
    int               cyc = 0;
    int               nbeats = 0;
    int               beat_cyc [256];
    bit               stall_seen = 1'b0;
    int               stall_rise_cyc = 0;
    logic [1:0]       rise_sel = '0;
    logic             rise_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input int p, input int id, input int b);
        return {8'(p), 8'(id), 16'(b)};
    endfunction

    task automatic load_pkt(input int p, input int id, input int n);
        for (int b = 0; b < n; b++) begin
            src_mem[p][src_wr[p]] = {(b == n - 1), mk_data(p, id, b)};
            src_wr[p]++;
        end
    endtask

    task automatic expect_pkt(input int p, input int id, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back({(b == n - 1), 2'(p), mk_data(p, id, b)});
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        areset = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            src_wr[i] = 0; src_rd[i] = 0; pops[i] = 0; hold_after[i] = 0; hold_rem[i] = 0;
        end
        exp_q.delete();
        nbeats = 0;
        stall_seen = 1'b0;
    endtask

    // Source and sink driver: advances each port after a handshake seen by the monitor.
    initial begin
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NPORT; i++) begin
                if (fire_s[i]) begin
                    src_rd[i]++;
                    pops[i]++;
                    if (hold_after[i] != 0 && pops[i] == hold_after[i]) hold_rem[i] = hold_len;
                end else if (hold_rem[i] > 0) begin
                    hold_rem[i]--;
                end
                if (hold_rem[i] == 0 && src_rd[i] < src_wr[i]) begin
                    bus.s_tvalid[i] = 1'b1;
                    {bus.s_tlast[i], bus.s_tdata[i*DW +: DW]} = src_mem[i][src_rd[i]];
                end else begin
                    bus.s_tvalid[i] = 1'b0;
                    bus.s_tlast[i]  = 1'b0;
                    bus.s_tdata[i*DW +: DW] = '0;
                end
            end
            bus.m_tready = tog_mode ? ~bus.m_tready : 1'b1;
        end
    end

    // Monitor: compares each delivered beat against the head of the expected queue.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            fire_s = bus.s_tvalid & bus.s_tready;
            if (bus.m_tvalid && bus.m_tready) begin
                if (nbeats < 256) beat_cyc[nbeats] = cyc;
                nbeats++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got sel=%0d data=0x%0h, expected no beat",
                             bus.m_tsel, bus.m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {bus.m_tlast, bus.m_tsel, bus.m_tdata}, e);
                end
            end
            if (stall_err === 1'b1 && !stall_seen) begin
                stall_seen     = 1'b1;
                stall_rise_cyc = cyc;
                rise_sel       = bus.m_tsel;
                rise_busy      = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle
        repeat (2) @(posedge clk);
        #2;
        areset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {bus.m_tvalid, bus.s_tready, busy, pkts_out}, '0);
        end

        // Equal weights: round-robin 0,1,2,3,0,1,2,3 with one bubble between grants
        do_reset();
        weight = 16'h1111;
        for (int id = 0; id < 2; id++) for (int p = 0; p < 4; p++) load_pkt(p, id, 4);
        for (int id = 0; id < 2; id++) for (int p = 0; p < 4; p++) expect_pkt(p, id, 4);
        wait_drain("equal");
        chk("equal_span", beat_cyc[nbeats-1] - beat_cyc[0] + 1, 39);
        chk("equal_pkts", pkts_out, 8);

        // Weighted: port0 weight 3, port1 weight 0 (treated as 1)
        do_reset();
        weight = 16'h1103;
        for (int id = 0; id < 6; id++) load_pkt(0, id, 2);
        for (int id = 0; id < 2; id++) load_pkt(1, id, 2);
        for (int id = 0; id < 3; id++) expect_pkt(0, id, 2);
        expect_pkt(1, 0, 2);
        for (int id = 3; id < 6; id++) expect_pkt(0, id, 2);
        expect_pkt(1, 1, 2);
        wait_drain("weighted");
        chk("weighted_span", beat_cyc[nbeats-1] - beat_cyc[0] + 1, 19);
        chk("weighted_pkts", pkts_out, 8);

        // Suppress mid-packet with toggling backpressure
        do_reset();
        weight = 16'h1111;
        tog_mode = 1'b1;
        load_pkt(1, 0, 5);
        expect_pkt(1, 0, 5);
        expect_pkt(2, 0, 2);
        expect_pkt(0, 0, 2);
        for (int k = 0; k < 100 && pops[1] < 1; k++) begin
            @(posedge clk); #2;
        end
        chk("supp_first_beat", pops[1], 1);
        arb_req_suppress = 4'b0010;
        load_pkt(2, 0, 2);
        load_pkt(0, 0, 2);
        load_pkt(1, 1, 3);
        wait_drain("suppress");
        repeat (20) @(posedge clk);
        #2;
        chk("supp_held", src_wr[1] - src_rd[1], 3);
        @(negedge clk);
        chk("supp_idle", busy, 0);
        @(posedge clk); #2;
        arb_req_suppress = 4'b0000;
        expect_pkt(1, 1, 3);
        wait_drain("unsuppress");
        tog_mode = 1'b0;

        // Mid-packet stall on port 2, port 3 waiting behind it
        do_reset();
        hold_after[2] = 2;
        hold_len = 20;
        load_pkt(2, 0, 5);
        load_pkt(3, 0, 2);
        expect_pkt(2, 0, 5);
        expect_pkt(3, 0, 2);
        wait_drain("stall");
        chk("stall_seen", stall_seen, 1);
        chk("stall_rise", stall_rise_cyc - beat_cyc[1], 17);
        chk("stall_sel", rise_sel, 2);
        chk("stall_busy", rise_busy, 1);
        chk("stall_gap", beat_cyc[2] - beat_cyc[1], 21);
        chk("stall_sticky", stall_err, 1);

        // Reset mid-packet on port 0 with ptr previously advanced to 3
        do_reset();
        chk("stall_cleared", stall_err, 0);
        load_pkt(2, 0, 2);
        expect_pkt(2, 0, 2);
        wait_drain("pre_reset");
        repeat (3) @(posedge clk);
        #2;
        chk("pre_pkts", pkts_out, 1);
        load_pkt(0, 0, 6);
        expect_pkt(0, 0, 6);
        for (int k = 0; k < 100 && pops[0] < 2; k++) begin
            @(posedge clk); #2;
        end
        areset = 1'b1;
        load_pkt(3, 0, 2);
        expect_pkt(3, 0, 2);
        @(posedge clk); #2;
        areset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", bus.m_tvalid, 0);
        chk("rst_pkts", pkts_out, 0);
        @(negedge clk);
        chk("regrant", {busy, bus.m_tsel}, {1'b1, 2'd0});
        wait_drain("post_reset");
        chk("post_pkts", pkts_out, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
